// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of one shared enabled D register.
// Define ARB_FIXED_PRIO_EN to switch to fixed priority (lowest index wins).
module reg_write_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 3
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   D_bus,
    output logic [NREQ-1:0]         ack,
    output logic                    enable,
    output logic [WIDTH-1:0]        D_out,
    output logic [1:0]              owner,
    output logic                    busy,
    output logic [WIDTH-1:0]        Q
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               found_s;
    logic [1:0]         winner_s;
    logic [WIDTH-1:0]   win_data_s;
    logic [1:0]         owner_r;
    logic [WIDTH-1:0]   d_out_r;
    logic [WIDTH-1:0]   q_r;
    logic [NREQ-1:0]    ack_s;
    logic               enable_s;
    logic               busy_s;

`ifdef ARB_FIXED_PRIO_EN
    // Winner search: lowest requesting index.
    always_comb begin
        found_s  = 1'b0;
        winner_s = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && req[i]) begin
                found_s  = 1'b1;
                winner_s = 2'(i);
            end else begin
                found_s  = found_s;
            end
        end
    end
`else
    logic [1:0] last_r;
    logic [2:0] idx_s;

    // Winner search: first request strictly after last, wrapping modulo NREQ.
    always_comb begin
        found_s  = 1'b0;
        winner_s = 2'd0;
        idx_s    = 3'd0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = {1'b0, last_r} + 3'(k);
            if (idx_s >= 3'(NREQ)) begin
                idx_s = idx_s - 3'(NREQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s[1:0]]) begin
                found_s  = 1'b1;
                winner_s = idx_s[1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end
`endif

    // Select the winner's data slice.
    always_comb begin
        win_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (winner_s == 2'(i)) begin
                win_data_s = D_bus[i*WIDTH +: WIDTH];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE:    next_state_s = found_s ? WRITE : IDLE;
            WRITE:   next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Grant capture, shared register write and round-robin pointer update.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            owner_r <= 2'd0;
            d_out_r <= {WIDTH{1'b0}};
            q_r     <= {WIDTH{1'b0}};
`ifndef ARB_FIXED_PRIO_EN
            last_r  <= 2'(NREQ - 1);
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        owner_r <= winner_s;
                        d_out_r <= win_data_s;
                    end else begin
                        owner_r <= owner_r;
                    end
                end
                WRITE: q_r <= d_out_r;
                DONE: begin
`ifndef ARB_FIXED_PRIO_EN
                    last_r <= owner_r;
`endif
                end
                default: q_r <= q_r;
            endcase
        end
    end

    // State-decoded handshake outputs.
    always_comb begin
        ack_s    = {NREQ{1'b0}};
        enable_s = (state_r == WRITE);
        busy_s   = (state_r != IDLE);
        if (state_r == DONE) begin
            ack_s[owner_r] = 1'b1;
        end else begin
            ack_s = {NREQ{1'b0}};
        end
    end

    assign ack    = ack_s;
    assign enable = enable_s;
    assign busy   = busy_s;
    assign D_out  = d_out_r;
    assign owner  = owner_r;
    assign Q      = q_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: stimulus pushes expected acks,
// a negedge monitor pops and compares on every ack pulse.
module tb_reg_write_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 3;

    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [11:0] D_bus = 12'h000;
    logic [2:0]  ack;
    logic        enable;
    logic [3:0]  D_out;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  Q;

    reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .Clk(Clk), .reset(reset), .req(req), .D_bus(D_bus),
        .ack(ack), .enable(enable), .D_out(D_out), .owner(owner),
        .busy(busy), .Q(Q)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0] ack;
        logic [1:0] owner;
        logic [3:0] q;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   en_cnt = 0;
    int   busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic push(input logic [2:0] a, input logic [1:0] o, input logic [3:0] q);
        exp_q.push_back({a, o, q});
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (ack == 3'b000 && n < 20);
        if (ack == 3'b000) begin
            checks++;
            $display("FAIL ack_timeout: no ack within %0d cycles", n);
        end
    endtask

    // Monitor: compare every ack pulse against the scoreboard head.
    always @(negedge Clk) begin
        exp_t e;
        if (!reset) begin
            en_cnt   = 0;
            busy_cnt = 0;
        end else begin
            if (enable) en_cnt++;
            if (busy) busy_cnt++;
            if (ack != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {29'd0, ack}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack",   {29'd0, ack},   {29'd0, e.ack});
                    check("owner", {30'd0, owner}, {30'd0, e.owner});
                    check("q",     {28'd0, Q},     {28'd0, e.q});
                    check("d_out", {28'd0, D_out}, {28'd0, e.q});
                end
                check("enable_cycles", en_cnt, 32'd1);
                check("busy_cycles", busy_cnt, 32'd2);
                en_cnt   = 0;
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(negedge Clk);
        check("rst_ack",    {29'd0, ack},   32'd0);
        check("rst_enable", {31'd0, enable}, 32'd0);
        check("rst_d_out",  {28'd0, D_out}, 32'd0);
        check("rst_owner",  {30'd0, owner}, 32'd0);
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_q",      {28'd0, Q},     32'd0);
        #2 reset = 1'b1;

        // No requests: nothing moves for 10 cycles.
        repeat (10) begin
            @(negedge Clk);
            check("idle_enable", {31'd0, enable}, 32'd0);
            check("idle_ack",    {29'd0, ack},    32'd0);
            check("idle_busy",   {31'd0, busy},   32'd0);
            check("idle_q",      {28'd0, Q},      32'd0);
        end

        // Single request from requester 0.
        D_bus = {4'h0, 4'h0, 4'hA};
        push(3'b001, 2'd0, 4'hA);
        req = 3'b001;
        wait_ack(n);
        check("t1_ack_latency", n, 32'd2);
        req = 3'b000;
        @(negedge Clk);
        check("t1_q_hold", {28'd0, Q}, 32'h0000000A);
        check("t1_idle_enable", {31'd0, enable}, 32'd0);

        // Reset, then all three requesting continuously.
        reset = 1'b0;
        @(negedge Clk);
        check("t2_rst_q", {28'd0, Q}, 32'd0);
        #2 reset = 1'b1;
        D_bus = {4'h3, 4'h2, 4'h1};
`ifdef ARB_FIXED_PRIO_EN
        repeat (4) push(3'b001, 2'd0, 4'h1);
`else
        push(3'b001, 2'd0, 4'h1);
        push(3'b010, 2'd1, 4'h2);
        push(3'b100, 2'd2, 4'h3);
        push(3'b001, 2'd0, 4'h1);
`endif
        req = 3'b111;
        wait_ack(n);
        for (int k = 0; k < 3; k++) begin
            wait_ack(n);
            check("t2_ack_gap", n, 32'd3);
        end
        req = 3'b000;
        @(negedge Clk);

        // Grant to requester 2, then 1 and 2 compete: 1 wins.
        D_bus = {4'h4, 4'h6, 4'h0};
        push(3'b100, 2'd2, 4'h4);
        req = 3'b100;
        wait_ack(n);
        req = 3'b000;
        @(negedge Clk);
        push(3'b010, 2'd1, 4'h6);
        req = 3'b110;
        wait_ack(n);
        req = 3'b000;
        @(negedge Clk);

        // Data change and request drop during WRITE do not affect the write.
        D_bus = {4'h0, 4'h5, 4'h0};
        push(3'b010, 2'd1, 4'h5);
        req = 3'b010;
        @(negedge Clk);
        check("t4_enable_in_write", {31'd0, enable}, 32'd1);
        D_bus = {4'h0, 4'hF, 4'h0};
        req = 3'b000;
        wait_ack(n);
        @(negedge Clk);

        // Write 7, then reset in the middle of the next WRITE.
        D_bus = {4'h0, 4'h0, 4'h7};
        push(3'b001, 2'd0, 4'h7);
        req = 3'b001;
        wait_ack(n);
        req = 3'b000;
        @(negedge Clk);
        D_bus = {4'h0, 4'h9, 4'h0};
        req = 3'b010;
        @(negedge Clk);
        check("t5_enable_in_write", {31'd0, enable}, 32'd1);
        check("t5_q_before_reset", {28'd0, Q}, 32'h00000007);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_q",      {28'd0, Q},      32'd0);
        check("t5_rst_busy",   {31'd0, busy},   32'd0);
        check("t5_rst_enable", {31'd0, enable}, 32'd0);
        check("t5_rst_ack",    {29'd0, ack},    32'd0);
        req = 3'b011;
        D_bus = {4'h0, 4'h9, 4'h8};
        @(negedge Clk);
        #2 reset = 1'b1;
        push(3'b001, 2'd0, 4'h8);
        wait_ack(n);
        req = 3'b000;

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
